// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: access-length encodings, the entry
// record and the length-to-byte-lane helper.
package store_buffer_pkg;

    localparam logic [1:0] LEN_NONE = 2'b00;
    localparam logic [1:0] LEN_BYTE = 2'b01;
    localparam logic [1:0] LEN_HALF = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic [1:0]  length;
    } sb_entry_t;

    // Bit k set when byte offset k (from the access address) is touched.
    function automatic logic [3:0] byte_mask(input logic [1:0] length);
        case (length)
            LEN_BYTE: byte_mask = 4'b0001;
            LEN_HALF: byte_mask = 4'b0011;
            LEN_WORD: byte_mask = 4'b1111;
            default:  byte_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/sb_overlap_check.sv
// Byte-overlap test between one buffered store and the current load.
// Addresses wrap at 2^32, so each byte pair is compared directly.
module sb_overlap_check
    import store_buffer_pkg::*;
(
    input  logic        entry_valid,
    input  logic [31:0] entry_address,
    input  logic [1:0]  entry_length,
    input  logic [31:0] load_address,
    input  logic [1:0]  load_length,
    output logic        overlap
);

    logic [3:0] ld_mask;
    logic [3:0] st_mask;
    logic       hit;

    assign ld_mask = byte_mask(load_length);
    assign st_mask = byte_mask(entry_length);

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (ld_mask[k] && st_mask[j] &&
                    ((load_address + 32'(k)) == (entry_address + 32'(j)))) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign overlap = entry_valid & hit;

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the memory stage and the memory write port,
// with a load-overlap stall so loads never read stale bytes.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             ST_valid,
    output logic             ST_ready,
    input  logic [31:0]      ST_address,
    input  logic [31:0]      ST_data,
    input  logic [1:0]       ST_length,
    input  logic             LD_valid,
    input  logic [31:0]      LD_address,
    input  logic [1:0]       LD_length,
    output logic             LD_stall,
    input  logic             MEM_wr_grant,
    output logic [1:0]       MEM_write_length,
    output logic [31:0]      MEM_write_address,
    output logic [31:0]      MEM_write_data,
    output logic             SB_empty,
    output logic [CNT_W-1:0] SB_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    sb_entry_t        entries [DEPTH];
    sb_entry_t        head_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             enq;
    logic             deq;
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ovl;

    // Ready ignores the grant so there is no grant-to-ready path.
    assign ST_ready = SYS_reset & (count != FULL);
    assign enq      = ST_valid & ST_ready & (ST_length != LEN_NONE);
    assign deq      = MEM_wr_grant & (count != '0);

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
        end
    end

    // Payload storage needs no reset; validity comes from head/count.
    always_ff @(posedge SYS_clk) begin
        if (enq) begin
            entries[tail] <= '{address: ST_address, data: ST_data, length: ST_length};
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_chk
        logic [PTR_W-1:0] off;
        assign off          = PTR_W'(g) - head;
        assign ent_valid[g] = CNT_W'(off) < count;

        sb_overlap_check u_chk (
            .entry_valid   (ent_valid[g]),
            .entry_address (entries[g].address),
            .entry_length  (entries[g].length),
            .load_address  (LD_address),
            .load_length   (LD_length),
            .overlap       (ovl[g])
        );
    end

    assign LD_stall = LD_valid & (LD_length != LEN_NONE) & (|ovl);

    assign head_entry        = entries[head];
    assign SB_empty          = (count == '0);
    assign SB_count          = count;
    assign MEM_write_length  = SB_empty ? LEN_NONE : head_entry.length;
    assign MEM_write_address = SB_empty ? 32'h0 : head_entry.address;
    assign MEM_write_data    = SB_empty ? 32'h0 : head_entry.data;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based
// reference model of the buffer contents.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_address;
    logic [31:0]      st_data;
    logic [1:0]       st_length;
    logic             ld_valid;
    logic [31:0]      ld_address;
    logic [1:0]       ld_length;
    logic             ld_stall;
    logic             grant;
    logic [1:0]       mem_len;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic             sb_empty;
    logic [CNT_W-1:0] sb_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  l;
    } ref_entry_t;

    ref_entry_t q[$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .SYS_clk           (clk),
        .SYS_reset         (rst_n),
        .ST_valid          (st_valid),
        .ST_ready          (st_ready),
        .ST_address        (st_address),
        .ST_data           (st_data),
        .ST_length         (st_length),
        .LD_valid          (ld_valid),
        .LD_address        (ld_address),
        .LD_length         (ld_length),
        .LD_stall          (ld_stall),
        .MEM_wr_grant      (grant),
        .MEM_write_length  (mem_len),
        .MEM_write_address (mem_addr),
        .MEM_write_data    (mem_data),
        .SB_empty          (sb_empty),
        .SB_count          (sb_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] l);
        case (l)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_stall();
        logic [31:0] lb, sb;
        if (!ld_valid || ld_length == 2'b00) return 1'b0;
        foreach (q[i]) begin
            for (int k = 0; k < nbytes(ld_length); k++) begin
                for (int j = 0; j < nbytes(q[i].l); j++) begin
                    lb = ld_address + 32'(k);
                    sb = q[i].a + 32'(j);
                    if (lb == sb) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic logic model_ready();
        return rst_n && (q.size() != DEPTH);
    endfunction

    task automatic check_model();
        chk("st_ready", 32'(st_ready), 32'(model_ready()));
        chk("sb_count", 32'(sb_count), 32'(q.size()));
        chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
        chk("mem_len",  32'(mem_len),  q.size() == 0 ? 32'h0 : 32'(q[0].l));
        chk("mem_addr", mem_addr,      q.size() == 0 ? 32'h0 : q[0].a);
        chk("mem_data", mem_data,      q.size() == 0 ? 32'h0 : q[0].d);
        chk("ld_stall", 32'(ld_stall), 32'(model_stall()));
    endtask

    task automatic step_model();
        logic do_enq;
        logic do_deq;
        if (!rst_n) begin
            q.delete();
        end else begin
            do_enq = st_valid && model_ready() && st_length != 2'b00;
            do_deq = grant && q.size() > 0;
            if (do_deq) void'(q.pop_front());
            if (do_enq) q.push_back('{a: st_address, d: st_data, l: st_length});
        end
    endtask

    task automatic set_in(input logic rst, input logic sv, input logic [1:0] sl,
                          input logic [31:0] sa, input logic [31:0] sd, input logic g,
                          input logic lv, input logic [1:0] ll, input logic [31:0] la);
        rst_n      = rst;
        st_valid   = sv;
        st_length  = sl;
        st_address = sa;
        st_data    = sd;
        grant      = g;
        ld_valid   = lv;
        ld_length  = ll;
        ld_address = la;
    endtask

    task automatic drive(input logic rst, input logic sv, input logic [1:0] sl,
                         input logic [31:0] sa, input logic [31:0] sd, input logic g);
        @(negedge clk);
        set_in(rst, sv, sl, sa, sd, g, 1'b0, 2'b00, 32'h0);
        #1;
        check_model();
        @(posedge clk);
        step_model();
    endtask

    task automatic probe(input logic [1:0] ll, input logic [31:0] la, input logic exp);
        @(negedge clk);
        set_in(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, ll, la);
        #1;
        chk("ld_stall_dir", 32'(ld_stall), 32'(exp));
        check_model();
        @(posedge clk);
        step_model();
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rst_count", 32'(sb_count), 32'h0);
        chk("rst_len",   32'(mem_len),  32'h0);

        // Single word, granted: visible the cycle after accept, then gone.
        drive(1'b1, 1'b1, 2'b11, 32'h100, 32'hDEADBEEF, 1'b1);
        #1;
        chk("first_len",  32'(mem_len), 32'h3);
        chk("first_addr", mem_addr,     32'h100);
        chk("first_data", mem_data,     32'hDEADBEEF);
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        #1;
        chk("first_empty", 32'(sb_empty), 32'h1);

        // Five stores with grant low: four accepted, fifth refused.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 2'(i % 3 + 1), 32'h400 + 32'(i * 8), 32'hA000 + 32'(i), 1'b0);
        end
        #1;
        chk("full_count", 32'(sb_count), 32'h4);
        chk("full_ready", 32'(st_ready), 32'h0);
        drain(5);

        // Half at 0x203 covers 0x203..0x204.
        drive(1'b1, 1'b1, 2'b10, 32'h203, 32'h1234, 1'b0);
        probe(2'b01, 32'h204, 1'b1);
        probe(2'b01, 32'h205, 1'b0);
        probe(2'b11, 32'h200, 1'b1);
        drain(2);

        // Word at 0xFFFFFFFE wraps to cover 0x0 and 0x1.
        drive(1'b1, 1'b1, 2'b11, 32'hFFFF_FFFE, 32'h55AA55AA, 1'b0);
        probe(2'b01, 32'h1, 1'b1);
        probe(2'b01, 32'h2, 1'b0);
        drain(2);

        // Full with grant: dequeue only; then simultaneous enq/deq.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 2'b11, 32'h600 + 32'(4 * i), 32'(i), 1'b0);
        drive(1'b1, 1'b1, 2'b11, 32'h700, 32'h77, 1'b1);
        #1;
        chk("full_deq_count", 32'(sb_count), 32'h3);
        drive(1'b1, 1'b1, 2'b11, 32'h704, 32'h78, 1'b1);
        #1;
        chk("enq_deq_count", 32'(sb_count), 32'h3);

        // Reset with pending entries discards them.
        drain(4);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'b01, 32'h800 + 32'(i), 32'(i), 1'b0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        #1;
        chk("rst_mid_count", 32'(sb_count), 32'h0);
        chk("rst_mid_len",   32'(mem_len),  32'h0);
        drain(3);

        // Random traffic in a small address window and near the wrap point.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] base;
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : 32'h100;
            @(negedge clk);
            set_in(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   base + 32'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), base + 32'($urandom_range(0, 15)));
            #1;
            check_model();
            @(posedge clk);
            step_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipeline's memory stage and the main memory write port. Accepts store requests (byte/half/word, any byte address) into a DEPTH-entry FIFO and drains them in order, one per granted cycle, onto the memory's write-length/address/data inputs. Detects loads that overlap any pending store and raises a stall so a load never reads stale bytes from memory.

## Interface
- DEPTH, 4, number of buffer entries (power of two, ≥2)
- CNT_W, $clog2(DEPTH)+1, width of occupancy count

- SYS_clk  in  1  system clock; all state updates on rising edge
- SYS_reset  in  1  synchronous, active-low reset (0 = reset)
- ST_valid  in  1  store request present
- ST_ready  out  1  buffer can accept a store this cycle
- ST_address  in  32  store byte address
- ST_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ST_length  in  2  01 byte, 10 half, 11 word; 00 = no-op
- LD_valid  in  1  load in memory stage this cycle
- LD_address  in  32  load byte address
- LD_length  in  2  same encoding as ST_length
- LD_stall  out  1  load overlaps a pending store; pipeline must hold the load
- MEM_wr_grant  in  1  memory write port granted to this block this cycle
- MEM_write_length  out  2  to memory; 00 when buffer empty
- MEM_write_address  out  32  to memory
- MEM_write_data  out  32  to memory
- SB_empty  out  1  no pending entries
- SB_count  out  CNT_W  number of pending entries

## Operation
- Entry = {address[31:0], data[31:0], length[1:0]}; storage indexed by head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
- ST_ready = (SB_count != DEPTH) and not in reset; independent of MEM_wr_grant (no combinational path grant→ready).
- Enqueue when ST_valid & ST_ready & ST_length != 00: write entry at tail, tail+1. ST_length 00 with ST_valid is accepted and discarded (no entry).
- Head presentation: when non-empty, MEM_write_* = head entry fields; when empty, MEM_write_length = 00, address/data = 0.
- Dequeue when MEM_wr_grant & !SB_empty: head+1 at the same edge the memory captures the write.
- Simultaneous enqueue and dequeue: count unchanged; allowed also when full-minus-zero is not reached (full rejects enqueue even if dequeuing).
- Overlap: load bytes {LD_address + k, k < n_ld}, entry bytes {addr + j, j < n_st}, n = 1/2/4 for 01/10/11; all sums 32-bit, wrapping at 2^32 (FFFF_FFFF + 1 = 0). Overlap if any byte address equal.
- LD_stall = LD_valid & LD_length != 00 & (overlap with any valid entry). Store being enqueued in the same cycle is not checked (one memory op issued per cycle).
- Ordering strictly FIFO; no merging or coalescing of entries.

## Timing
- Reset (SYS_reset = 0 at edge): head = tail = 0, count = 0. Outputs during/after reset until first enqueue: ST_ready 0 during reset then 1, SB_empty 1, SB_count 0, MEM_write_length 00, MEM_write_address/data 0, LD_stall 0. Reset mid-drain discards all entries; no write issued after the reset edge.
- Store accepted at edge N appears on MEM_write_* during cycle N+1 (if buffer was empty); earliest memory write at edge N+1 if granted.
- LD_stall combinational from LD_* and registered entry state; deasserts the cycle after the last overlapping entry is dequeued.
- SB_count, SB_empty registered-state derived; update the cycle after enqueue/dequeue edge.
- Grant held low: entries remain, head outputs stable.

## Structure
- Length encodings (LEN_NONE/BYTE/HALF/WORD) and byte-count function in global.vh, shared with the memory and load/store decode.
- Sub-module sb_overlap_check: one instance per entry; inputs entry valid/address/length and load address/length, output overlap bit (16 byte comparators).

## Test plan
- Reset then store word 0xDEADBEEF @0x100, grant=1 -> cycle after accept MEM_write_length=11, addr 0x100, data 0xDEADBEEF; next cycle SB_empty=1.
- Grant=0, issue 5 stores with DEPTH=4 -> first 4 accepted, ST_ready=0 on 5th, SB_count=4; raise grant -> drained in issue order, one per cycle.
- Pending half @0x203; load byte @0x204 -> LD_stall=1; load byte @0x205 -> 0; load word @0x200 -> 1.
- Pending word @0xFFFF_FFFE; load byte @0x0000_0001 -> LD_stall=1 (wrap); load byte @0x2 -> 0.
- Full buffer, grant=1, ST_valid=1 -> no enqueue, one dequeue, count 3; next cycle enqueue + dequeue -> count stays 3.
- Assert SYS_reset=0 with 3 pending entries -> next cycle count 0, MEM_write_length 00, no further writes.
